// File: rtl/mem_access_controller.sv
// Sequencing front end for Main_Memory: arbitrates the fetch and load/store ports and
// issues one guarded (range check + timeout) memory transaction at a time.
//
// state    | meaning
// ---------+------------------------------------------------------------------
// S_IDLE   | no transaction; requests evaluated, winner latched
// S_ACCESS | memory flags driven, waiting for mem_done or timeout
// S_RESP   | one-cycle ack to the granted port with err/data, then back to idle
module mem_access_controller #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int MEM_DEPTH      = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [12:0] fetch_addr,
    output logic        fetch_ack,
    output logic [12:0] fetch_data,
    input  logic        ls_req,
    input  logic        ls_write,
    input  logic [12:0] ls_addr,
    input  logic [12:0] ls_wdata,
    output logic        ls_ack,
    output logic [12:0] ls_rdata,
    output logic        err,
    output logic        busy,
    output logic [12:0] mem_address,
    output logic [12:0] mem_data_in,
    output logic        mem_write,
    output logic        mem_read,
    output logic        mem_instruction,
    input  logic [12:0] mem_data_out,
    input  logic        mem_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [13:0] DEPTH    = 14'(MEM_DEPTH);
    localparam logic [7:0]  TO_LOAD  = 8'(TIMEOUT_CYCLES);
    localparam logic [12:0] ERR_DATA = 13'h1FFF;

    state_t      state;
    logic        last_ls;
    logic        port_ls;
    logic        is_store;
    logic [7:0]  to_cnt;

    logic        any_req;
    logic        grant_ls;
    logic [12:0] grant_addr;
    logic        grant_oor;

    logic        resp_fire;
    logic        resp_err;
    logic        resp_ls;
    logic [12:0] resp_data;

    // On a tie the port that was not served last wins; last_ls resets to "fetch".
    assign any_req    = fetch_req | ls_req;
    assign grant_ls   = ls_req & (~fetch_req | ~last_ls);
    assign grant_addr = grant_ls ? ls_addr : fetch_addr;
    assign grant_oor  = ({1'b0, grant_addr} >= DEPTH);
    assign busy       = (state != S_IDLE);

    always_comb begin
        resp_fire = 1'b0;
        resp_err  = 1'b0;
        resp_ls   = port_ls;
        resp_data = '0;
        case (state)
            S_IDLE: begin
                if (any_req && grant_oor) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                    resp_ls   = grant_ls;
                    resp_data = ERR_DATA;
                end
            end
            S_ACCESS: begin
                if (mem_done) begin
                    resp_fire = 1'b1;
                    resp_data = is_store ? '0 : mem_data_out;
                end else if (to_cnt == '0) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                    resp_data = ERR_DATA;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            last_ls         <= 1'b0;
            port_ls         <= 1'b0;
            is_store        <= 1'b0;
            to_cnt          <= '0;
            fetch_ack       <= 1'b0;
            ls_ack          <= 1'b0;
            err             <= 1'b0;
            fetch_data      <= '0;
            ls_rdata        <= '0;
            mem_address     <= '0;
            mem_data_in     <= '0;
            mem_write       <= 1'b0;
            mem_read        <= 1'b0;
            mem_instruction <= 1'b0;
        end else begin
            fetch_ack <= resp_fire & ~resp_ls;
            ls_ack    <= resp_fire & resp_ls;
            err       <= resp_fire & resp_err;
            if (resp_fire && !resp_ls) begin
                fetch_data <= resp_data;
            end
            if (resp_fire && resp_ls) begin
                ls_rdata <= resp_data;
            end

            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        port_ls  <= grant_ls;
                        is_store <= grant_ls & ls_write;
                        if (grant_oor) begin
                            state <= S_RESP;
                        end else begin
                            state           <= S_ACCESS;
                            to_cnt          <= TO_LOAD;
                            mem_address     <= grant_addr;
                            mem_data_in     <= grant_ls ? ls_wdata : '0;
                            mem_write       <= grant_ls & ls_write;
                            mem_read        <= ~(grant_ls & ls_write);
                            mem_instruction <= ~grant_ls;
                        end
                    end
                end
                S_ACCESS: begin
                    // Timer runs TIMEOUT_CYCLES+1 access cycles before giving up.
                    if (resp_fire) begin
                        state           <= S_RESP;
                        mem_write       <= 1'b0;
                        mem_read        <= 1'b0;
                        mem_instruction <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt - 8'd1;
                    end
                end
                S_RESP: begin
                    last_ls <= port_ls;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller: directed scenarios plus randomized rounds checked
// against a transaction-level model of arbitration, range check, timeout and memory.
module tb_mem_access_controller;

    localparam int TO    = 4;
    localparam int DEPTH = 13;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [12:0] fetch_addr;
    logic        fetch_ack;
    logic [12:0] fetch_data;
    logic        ls_req;
    logic        ls_write;
    logic [12:0] ls_addr;
    logic [12:0] ls_wdata;
    logic        ls_ack;
    logic [12:0] ls_rdata;
    logic        err;
    logic        busy;
    logic [12:0] mem_address;
    logic [12:0] mem_data_in;
    logic        mem_write;
    logic        mem_read;
    logic        mem_instruction;
    logic [12:0] mem_data_out;
    logic        mem_done;

    int checks   = 0;
    int failures = 0;

    logic [12:0] mem_arr [0:DEPTH-1];
    logic [12:0] ref_mem [0:DEPTH-1];
    bit          mem_en  = 1'b1;
    int          lat_max = 0;

    logic [12:0] exp_fd;
    logic [12:0] exp_lr;
    bit          m_last_ls;

    mem_access_controller #(.TIMEOUT_CYCLES(TO), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .ls_req(ls_req), .ls_write(ls_write), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata), .err(err), .busy(busy),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_write(mem_write),
        .mem_read(mem_read), .mem_instruction(mem_instruction),
        .mem_data_out(mem_data_out), .mem_done(mem_done)
    );

    always #5 clk = ~clk;

    // Memory model: Done on a negedge after a random number of access cycles.
    initial begin
        int         wcnt;
        int         lat;
        bit         active;
        logic [3:0] idx;
        wcnt = 0; lat = 0; active = 1'b0;
        mem_done = 1'b0;
        mem_data_out = '0;
        forever begin
            @(negedge clk);
            mem_done = 1'b0;
            if (mem_read || mem_write || mem_instruction) begin
                checks++;
                if ((mem_read && mem_write) || (mem_instruction && !mem_read) || fetch_ack || ls_ack
                    || int'(mem_address) >= DEPTH) begin
                    failures++;
                    $display("FAIL flag_invariant: read=%0b write=%0b instr=%0b fetch_ack=%0b ls_ack=%0b addr=%0d, required exclusive flags, no ack, addr<%0d",
                             mem_read, mem_write, mem_instruction, fetch_ack, ls_ack, mem_address, DEPTH);
                end
                if (!active) begin
                    active = 1'b1;
                    wcnt = 0;
                    lat = $urandom_range(0, lat_max);
                end
                if (mem_en && wcnt >= lat && int'(mem_address) < DEPTH) begin
                    idx = mem_address[3:0];
                    mem_done = 1'b1;
                    if (mem_write) mem_arr[idx] = mem_data_in;
                    else           mem_data_out = mem_arr[idx];
                end
                wcnt++;
            end else begin
                active = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        reset = 1'b1;
        fetch_req = 1'b0;
        ls_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_fd = '0;
        exp_lr = '0;
        m_last_ls = 1'b0;
    endtask

    task automatic wait_ack(input int max_cyc, input int scr_after, input bit scr_ls,
                            output int port, output int ncyc);
        port = 0;
        ncyc = 0;
        while (port == 0 && ncyc < max_cyc) begin
            @(posedge clk);
            #1;
            ncyc++;
            if (fetch_ack || ls_ack) port = int'({ls_ack, fetch_ack});
            if (ncyc == scr_after) begin
                if (scr_ls) begin
                    ls_addr  = 13'($urandom);
                    ls_wdata = 13'($urandom);
                    ls_write = ~ls_write;
                end else begin
                    fetch_addr = 13'($urandom);
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({fetch_ack, ls_ack, err, busy, mem_write, mem_read, mem_instruction,
             mem_address, mem_data_in, fetch_data, ls_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got acks=%b%b err=%b busy=%b flags=%b%b%b addr=%h din=%h fd=%h lr=%h, required all 0",
                     fetch_ack, ls_ack, err, busy, mem_write, mem_read, mem_instruction,
                     mem_address, mem_data_in, fetch_data, ls_rdata);
        end
    endtask

    task automatic test_single_fetch();
        mem_arr[5] = 13'h0A3C;
        ref_mem[5] = 13'h0A3C;
        lat_max = 0;
        fetch_addr = 13'd5;
        fetch_req = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({mem_read, mem_instruction, mem_write} !== 3'b110 || mem_address !== 13'd5 || busy !== 1'b1) begin
            failures++;
            $display("FAIL fetch_cycle1: got r/i/w=%b%b%b addr=%0d busy=%b, required 110 addr=5 busy=1",
                     mem_read, mem_instruction, mem_write, mem_address, busy);
        end
        @(posedge clk); #1;
        fetch_req = 1'b0;
        checks++;
        if (fetch_ack !== 1'b1 || ls_ack !== 1'b0 || fetch_data !== 13'h0A3C || err !== 1'b0) begin
            failures++;
            $display("FAIL fetch_ack: got ack=%b ls_ack=%b data=%h err=%b, required 1 0 0a3c 0",
                     fetch_ack, ls_ack, fetch_data, err);
        end
        checks++;
        if ({mem_read, mem_instruction, mem_write} !== 3'b000) begin
            failures++;
            $display("FAIL fetch_resp_flags: got %b%b%b, required 000", mem_read, mem_instruction, mem_write);
        end
        @(posedge clk); #1;
        checks++;
        if (fetch_ack !== 1'b0 || busy !== 1'b0 || fetch_data !== 13'h0A3C) begin
            failures++;
            $display("FAIL fetch_after: got ack=%b busy=%b data=%h, required 0 0 0a3c", fetch_ack, busy, fetch_data);
        end
        exp_fd = 13'h0A3C;
        m_last_ls = 1'b0;
    endtask

    task automatic test_store_load();
        int port, n;
        ls_addr = 13'd3;
        ls_wdata = 13'h1234;
        ls_write = 1'b1;
        ls_req = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({mem_write, mem_read, mem_instruction} !== 3'b100 || mem_data_in !== 13'h1234 || mem_address !== 13'd3) begin
            failures++;
            $display("FAIL store_cycle1: got w/r/i=%b%b%b din=%h addr=%0d, required 100 1234 3",
                     mem_write, mem_read, mem_instruction, mem_data_in, mem_address);
        end
        @(posedge clk); #1;
        ls_req = 1'b0;
        checks++;
        if (ls_ack !== 1'b1 || err !== 1'b0 || ls_rdata !== 13'h0000) begin
            failures++;
            $display("FAIL store_ack: got ack=%b err=%b rdata=%h, required 1 0 0000", ls_ack, err, ls_rdata);
        end
        ref_mem[3] = 13'h1234;
        @(posedge clk); #1;
        ls_write = 1'b0;
        ls_req = 1'b1;
        wait_ack(8, 0, 1'b0, port, n);
        ls_req = 1'b0;
        checks++;
        if (port != 2 || n != 2 || ls_rdata !== 13'h1234 || err !== 1'b0) begin
            failures++;
            $display("FAIL load_back: got port=%0d lat=%0d rdata=%h err=%b, required 2 2 1234 0", port, n, ls_rdata, err);
        end
        @(posedge clk); #1;
        exp_lr = 13'h1234;
        m_last_ls = 1'b1;
    endtask

    task automatic test_back_to_back_tie();
        int port, n;
        int exp_port [3] = '{2, 1, 2};
        do_reset();
        fetch_addr = 13'd7;
        ls_addr = 13'd8;
        ls_write = 1'b0;
        fetch_req = 1'b1;
        ls_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_ack(10, 0, 1'b0, port, n);
            if (i == 2) begin
                fetch_req = 1'b0;
                ls_req = 1'b0;
            end
            checks++;
            if (port != exp_port[i] || n != ((i == 0) ? 2 : 3) || err !== 1'b0) begin
                failures++;
                $display("FAIL tie_order[%0d]: got port=%0d lat=%0d err=%b, required port=%0d lat=%0d err=0",
                         i, port, n, err, exp_port[i], (i == 0) ? 2 : 3);
            end
            checks++;
            if ((port == 1 && fetch_data !== ref_mem[7]) || (port == 2 && ls_rdata !== ref_mem[8])) begin
                failures++;
                $display("FAIL tie_data[%0d]: got fd=%h lr=%h, required fd=%h lr=%h",
                         i, fetch_data, ls_rdata, ref_mem[7], ref_mem[8]);
            end
        end
        @(posedge clk); #1;
        exp_fd = ref_mem[7];
        exp_lr = ref_mem[8];
        m_last_ls = 1'b1;
    endtask

    task automatic test_out_of_range();
        ls_addr = 13'd13;
        ls_write = 1'b0;
        ls_req = 1'b1;
        @(posedge clk); #1;
        ls_req = 1'b0;
        checks++;
        if (ls_ack !== 1'b1 || err !== 1'b1 || ls_rdata !== 13'h1FFF
            || {mem_read, mem_write, mem_instruction} !== 3'b000) begin
            failures++;
            $display("FAIL oor_ack: got ack=%b err=%b rdata=%h flags=%b%b%b, required 1 1 1fff 000",
                     ls_ack, err, ls_rdata, mem_read, mem_write, mem_instruction);
        end
        @(posedge clk); #1;
        checks++;
        if (ls_ack !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL oor_after: got ack=%b err=%b busy=%b, required 0 0 0", ls_ack, err, busy);
        end
        exp_lr = 13'h1FFF;
        m_last_ls = 1'b1;
    endtask

    task automatic test_timeout();
        bit bad;
        mem_en = 1'b0;
        fetch_addr = 13'd2;
        fetch_req = 1'b1;
        bad = 1'b0;
        for (int c = 1; c <= TO + 1; c++) begin
            @(posedge clk); #1;
            if (fetch_ack !== 1'b0 || mem_read !== 1'b1 || mem_instruction !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL timeout_wait: early ack or flags missing in cycles 1..%0d, required flags high and no ack", TO + 1);
        end
        @(posedge clk); #1;
        fetch_req = 1'b0;
        checks++;
        if (fetch_ack !== 1'b1 || err !== 1'b1 || fetch_data !== 13'h1FFF
            || {mem_read, mem_instruction} !== 2'b00) begin
            failures++;
            $display("FAIL timeout_ack: got ack=%b err=%b data=%h flags=%b%b in cycle %0d, required 1 1 1fff 00",
                     fetch_ack, err, fetch_data, mem_read, mem_instruction, TO + 2);
        end
        mem_en = 1'b1;
        @(posedge clk); #1;
        exp_fd = 13'h1FFF;
        m_last_ls = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit bad;
        ls_addr = 13'd4;
        ls_write = 1'b0;
        ls_req = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mem_read !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_access: got read=%b busy=%b, required 1 1", mem_read, busy);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        ls_req = 1'b0;
        checks++;
        if ({fetch_ack, ls_ack, err, busy, mem_write, mem_read, mem_instruction,
             mem_address, mem_data_in, fetch_data, ls_rdata} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs: got acks=%b%b err=%b busy=%b flags=%b%b%b addr=%h din=%h fd=%h lr=%h, required all 0",
                     fetch_ack, ls_ack, err, busy, mem_write, mem_read, mem_instruction,
                     mem_address, mem_data_in, fetch_data, ls_rdata);
        end
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ls_ack !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL rstmid_no_ack: ack or busy seen after reset, required none");
        end
        exp_fd = '0;
        exp_lr = '0;
        m_last_ls = 1'b0;
    endtask

    function automatic logic [12:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 13'($urandom_range(DEPTH, 8191));
        return 13'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic test_random();
        int port, n;
        for (int r = 0; r < 80; r++) begin
            bit fp, lp, lw, wls, first, exp_err;
            logic [12:0] fa, la, wd, addr, exp_data;
            fp = 1'($urandom_range(0, 1));
            lp = 1'($urandom_range(0, 1));
            if (!fp && !lp) lp = 1'b1;
            mem_en = ($urandom_range(0, 9) != 0);
            lat_max = $urandom_range(0, 3);
            fa = rand_addr();
            la = rand_addr();
            lw = 1'($urandom_range(0, 1));
            wd = 13'($urandom);
            fetch_addr = fa;
            ls_addr = la;
            ls_write = lw;
            ls_wdata = wd;
            fetch_req = fp;
            ls_req = lp;
            first = 1'b1;
            while (fp || lp) begin
                wls = lp && (!fp || !m_last_ls);
                addr = wls ? la : fa;
                if (int'(addr) >= DEPTH || !mem_en) begin
                    exp_err = 1'b1;
                    exp_data = 13'h1FFF;
                end else begin
                    exp_err = 1'b0;
                    if (wls && lw) begin
                        exp_data = '0;
                        ref_mem[addr[3:0]] = wd;
                    end else begin
                        exp_data = ref_mem[addr[3:0]];
                    end
                end
                if (wls) exp_lr = exp_data;
                else     exp_fd = exp_data;
                wait_ack(TO + 5, first ? 1 : 2, wls, port, n);
                if (wls) begin
                    ls_req = 1'b0;
                    lp = 1'b0;
                end else begin
                    fetch_req = 1'b0;
                    fp = 1'b0;
                end
                m_last_ls = wls;
                checks++;
                if (port != (wls ? 2 : 1) || err !== exp_err) begin
                    failures++;
                    $display("FAIL rand_grant[%0d]: got port=%0d err=%b, required port=%0d err=%b",
                             r, port, err, wls ? 2 : 1, exp_err);
                end
                checks++;
                if (fetch_data !== exp_fd || ls_rdata !== exp_lr) begin
                    failures++;
                    $display("FAIL rand_data[%0d]: got fd=%h lr=%h, required fd=%h lr=%h",
                             r, fetch_data, ls_rdata, exp_fd, exp_lr);
                end
                if (int'(addr) >= DEPTH) begin
                    checks++;
                    if (n != (first ? 1 : 2)) begin
                        failures++;
                        $display("FAIL rand_oor_latency[%0d]: got %0d, required %0d", r, n, first ? 1 : 2);
                    end
                end
                first = 1'b0;
            end
            @(posedge clk); #1;
        end
        mem_en = 1'b1;
        lat_max = 0;
    endtask

    initial begin
        reset = 1'b1;
        fetch_req = 1'b0;
        fetch_addr = '0;
        ls_req = 1'b0;
        ls_write = 1'b0;
        ls_addr = '0;
        ls_wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [12:0] v;
            v = 13'($urandom);
            mem_arr[i] = v;
            ref_mem[i] = v;
        end
        test_reset();
        test_single_fetch();
        test_store_load();
        test_back_to_back_tie();
        test_out_of_range();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
